// File: rtl/priority_decoder3_8_seq_if.sv
// Bus bundle between the upstream priority encoder / consumer and the
// receive-side decoder. The master modport is the environment driving
// encoded requests and ready; the slave modport is the decoder itself.
interface priority_decoder3_8_seq_if #(
  parameter int OVR_W = 8
);
  logic [2:0]       in_data;
  logic             in_gs;
  logic             in_enable;
  logic             in_ready;
  logic [7:0]       out_grant;
  logic [2:0]       out_data;
  logic             out_valid;
  logic [7:0]       out_pending;
  logic             out_empty;
  logic             out_overrun;
  logic [OVR_W-1:0] out_ovr_count;

  modport master (
    output in_data, in_gs, in_enable, in_ready,
    input  out_grant, out_data, out_valid, out_pending,
           out_empty, out_overrun, out_ovr_count
  );

  modport slave (
    input  in_data, in_gs, in_enable, in_ready,
    output out_grant, out_data, out_valid, out_pending,
           out_empty, out_overrun, out_ovr_count
  );
endinterface

// File: rtl/priority_decoder3_8_seq.sv
// Receive side of the 8-to-3 priority path: decodes encoded requests into a
// pending register and dispatches them one at a time, highest index first,
// over a valid/ready handshake with a programmable idle gap between grants.
module priority_decoder3_8_seq #(
  parameter int HOLD_CYCLES = 2,
  parameter int OVR_W       = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  priority_decoder3_8_seq_if.slave    bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [3:0]       HOLD_LD = 4'(HOLD_CYCLES);
  localparam logic [OVR_W-1:0] OVR_MAX = {OVR_W{1'b1}};
  localparam logic [OVR_W-1:0] OVR_ONE = {{(OVR_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [7:0]       grant_r;
  logic [2:0]       data_r;
  logic             valid_r;
  logic [3:0]       hold_r;
  logic [7:0]       pending_r;
  logic             empty_r;
  logic             overrun_r;
  logic [OVR_W-1:0] ovr_count_r;

  logic             hit_s;
  logic [7:0]       req_mask_s;
  logic             overrun_s;
  logic [2:0]       sel_s;
  logic             issue_s;
  logic             accept_s;
  logic [7:0]       pending_next_s;
  logic             valid_next_s;

  // Highest-index pending line; later (higher) indices overwrite lower ones.
  always_comb begin
    sel_s = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pending_r[i]) begin
        sel_s = 3'(i);
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // Capture, overrun detection, dispatch decisions and next-state pending.
  // A line being presented and not accepted this edge counts as busy; once
  // the handshake completes, the same line may be requested again.
  always_comb begin
    hit_s       = bus.in_gs && bus.in_enable;
    req_mask_s  = 8'b0000_0001 << bus.in_data;
    issue_s     = (state_r == IDLE) && bus.in_enable && (pending_r != 8'h00);
    accept_s    = (state_r == GRANT) && bus.in_ready;
    overrun_s   = hit_s &&
                  (((pending_r & req_mask_s) != 8'h00) ||
                   ((state_r == GRANT) && !bus.in_ready &&
                    ((grant_r & req_mask_s) != 8'h00)));
    pending_next_s = pending_r;
    if (issue_s) begin
      pending_next_s = pending_next_s & ~(8'b0000_0001 << sel_s);
    end else begin
      pending_next_s = pending_next_s;
    end
    if (hit_s && !overrun_s) begin
      pending_next_s = pending_next_s | req_mask_s;
    end else begin
      pending_next_s = pending_next_s;
    end
    if (issue_s) begin
      valid_next_s = 1'b1;
    end else if (accept_s) begin
      valid_next_s = 1'b0;
    end else begin
      valid_next_s = valid_r;
    end
  end

  // Dispatch FSM with registered grant outputs; a grant is never preempted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      grant_r <= 8'h00;
      data_r  <= 3'd0;
      valid_r <= 1'b0;
      hold_r  <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (issue_s) begin
            state_r <= GRANT;
            grant_r <= 8'b0000_0001 << sel_s;
            data_r  <= sel_s;
            valid_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT: begin
          if (bus.in_ready) begin
            grant_r <= 8'h00;
            data_r  <= 3'd0;
            valid_r <= 1'b0;
            if (HOLD_LD == 4'd0) begin
              state_r <= IDLE;
              hold_r  <= 4'd0;
            end else begin
              state_r <= HOLD;
              hold_r  <= HOLD_LD;
            end
          end else begin
            state_r <= GRANT;
          end
        end
        HOLD: begin
          if (hold_r <= 4'd1) begin
            state_r <= IDLE;
            hold_r  <= 4'd0;
          end else begin
            hold_r  <= hold_r - 4'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= 8'h00;
          data_r  <= 3'd0;
          valid_r <= 1'b0;
          hold_r  <= 4'd0;
        end
      endcase
    end
  end

  // Pending register, empty flag, overrun pulse and saturating overrun count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r   <= 8'h00;
      empty_r     <= 1'b1;
      overrun_r   <= 1'b0;
      ovr_count_r <= {OVR_W{1'b0}};
    end else begin
      pending_r <= pending_next_s;
      empty_r   <= (pending_next_s == 8'h00) && !valid_next_s;
      overrun_r <= overrun_s;
      if (overrun_s && (ovr_count_r != OVR_MAX)) begin
        ovr_count_r <= ovr_count_r + OVR_ONE;
      end else begin
        ovr_count_r <= ovr_count_r;
      end
    end
  end

  assign bus.out_grant     = grant_r;
  assign bus.out_data      = data_r;
  assign bus.out_valid     = valid_r;
  assign bus.out_pending   = pending_r;
  assign bus.out_empty     = empty_r;
  assign bus.out_overrun   = overrun_r;
  assign bus.out_ovr_count = ovr_count_r;
endmodule

// File: tb/tb_priority_decoder3_8_seq.sv
// Bench for priority_decoder3_8_seq: directed scenarios followed by random
// traffic, all compared every cycle against a behavioural reference model.
module tb_priority_decoder3_8_seq;
  localparam int HOLD  = 2;
  localparam int OVR_W = 8;
  localparam int OVR_SAT = (1 << OVR_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  priority_decoder3_8_seq_if #(.OVR_W(OVR_W)) bus ();
  priority_decoder3_8_seq #(.HOLD_CYCLES(HOLD), .OVR_W(OVR_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Reference model: set of waiting lines, the line on offer (-1 = none),
  // idle cycles still owed after an acceptance, overrun pulse and count.
  bit m_pend[8];
  int m_cur;
  int m_gap;
  int m_cnt;
  bit m_ovr;

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
    m_cur = -1; m_gap = 0; m_cnt = 0; m_ovr = 1'b0;
  endtask

  task automatic m_step();
    bit cap, ovr, acc;
    int j, k;
    cap = bus.in_gs && bus.in_enable;
    j   = int'(bus.in_data);
    ovr = cap && (m_pend[j] || (m_cur == j && !bus.in_ready));
    acc = (m_cur >= 0) && bus.in_ready;
    k = -1;
    if (m_cur < 0) begin
      if (m_gap > 0) m_gap--;
      else if (bus.in_enable)
        for (int i = 0; i < 8; i++) if (m_pend[i]) k = i;
    end
    if (acc) begin m_cur = -1; m_gap = HOLD; end
    if (k >= 0) begin m_cur = k; m_pend[k] = 1'b0; end
    if (cap && !ovr) m_pend[j] = 1'b1;
    m_ovr = ovr;
    if (ovr && m_cnt < OVR_SAT) m_cnt++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    logic [7:0] pv;
    bit empty;
    for (int i = 0; i < 8; i++) pv[i] = m_pend[i];
    empty = (pv == 8'h00) && (m_cur < 0);
    chk({tag, ".grant"},   32'(bus.out_grant),     (m_cur >= 0) ? 32'(1 << m_cur) : 32'd0);
    chk({tag, ".data"},    32'(bus.out_data),      (m_cur >= 0) ? 32'(m_cur) : 32'd0);
    chk({tag, ".valid"},   32'(bus.out_valid),     32'(m_cur >= 0));
    chk({tag, ".pending"}, 32'(bus.out_pending),   32'(pv));
    chk({tag, ".empty"},   32'(bus.out_empty),     32'(empty));
    chk({tag, ".overrun"}, 32'(bus.out_overrun),   32'(m_ovr));
    chk({tag, ".ovrcnt"},  32'(bus.out_ovr_count), 32'(m_cnt));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    m_step();
    cyc++;
    #1;
    check_all(tag);
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (bus.out_valid === 1'b1) break;
      tick(tag);
    end
    chk({tag, ".timeout"}, 32'(bus.out_valid), 32'd1);
  endtask

  int gcyc[$];
  int gidx[$];
  int ovr_pulses;

  initial begin
    bus.in_data = 3'd0; bus.in_gs = 1'b0; bus.in_enable = 1'b0; bus.in_ready = 1'b0;
    m_reset();

    // Reset then idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_all("reset");
    chk("reset.empty_const", 32'(bus.out_empty), 32'd1);

    // Single request on line 5
    bus.in_enable = 1'b1; bus.in_ready = 1'b1;
    bus.in_data = 3'd5; bus.in_gs = 1'b1;
    tick("single1");
    chk("single.pending", 32'(bus.out_pending), 32'h20);
    bus.in_gs = 1'b0;
    tick("single2");
    chk("single.grant", 32'(bus.out_grant), 32'h20);
    chk("single.data",  32'(bus.out_data),  32'd5);
    tick("single3");
    chk("single.empty", 32'(bus.out_empty), 32'd1);

    // Priority ordering: requests 1, 6, 3 arrive during the hold gap
    bus.in_gs = 1'b1; bus.in_data = 3'd1; tick("prio");
    bus.in_data = 3'd6; tick("prio");
    bus.in_data = 3'd3; tick("prio");
    if (bus.out_valid === 1'b1) begin gcyc.push_back(cyc); gidx.push_back(int'(bus.out_data)); end
    bus.in_gs = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick("prio");
      if (bus.out_valid === 1'b1) begin gcyc.push_back(cyc); gidx.push_back(int'(bus.out_data)); end
    end
    chk("prio.count", 32'(gidx.size()), 32'd3);
    if (gidx.size() == 3) begin
      chk("prio.first",  32'(gidx[0]), 32'd6);
      chk("prio.second", 32'(gidx[1]), 32'd3);
      chk("prio.third",  32'(gidx[2]), 32'd1);
      chk("prio.gap1", 32'(gcyc[1] - gcyc[0]), 32'(HOLD + 2));
      chk("prio.gap2", 32'(gcyc[2] - gcyc[1]), 32'(HOLD + 2));
    end

    // Backpressure: grant 2 held while 7 arrives
    bus.in_ready = 1'b0;
    bus.in_gs = 1'b1; bus.in_data = 3'd2; tick("bp");
    bus.in_gs = 1'b0; tick("bp");
    for (int i = 0; i < 5; i++) begin
      bus.in_gs = (i == 0); bus.in_data = 3'd7;
      tick("bp_hold");
      chk("bp.grant_held", 32'(bus.out_grant), 32'h04);
    end
    bus.in_gs = 1'b0; bus.in_ready = 1'b1;
    tick("bp_accept");
    wait_valid("bp_wait", 10);
    chk("bp.grant7", 32'(bus.out_grant), 32'h80);
    repeat (4) tick("bp_drain");

    // Overrun: 4 pending twice, then once while granted
    ovr_pulses = 0;
    bus.in_ready = 1'b0;
    bus.in_gs = 1'b1; bus.in_data = 3'd3; tick("ovr");
    bus.in_data = 3'd4; tick("ovr");
    ovr_pulses += int'(bus.out_overrun);
    tick("ovr");
    ovr_pulses += int'(bus.out_overrun);
    bus.in_gs = 1'b0; tick("ovr");
    bus.in_ready = 1'b1; tick("ovr_acc3");
    bus.in_ready = 1'b0;
    wait_valid("ovr_wait", 10);
    chk("ovr.grant4", 32'(bus.out_grant), 32'h10);
    bus.in_gs = 1'b1; bus.in_data = 3'd4; tick("ovr_granted");
    ovr_pulses += int'(bus.out_overrun);
    bus.in_gs = 1'b0; tick("ovr");
    ovr_pulses += int'(bus.out_overrun);
    chk("ovr.pulses", 32'(ovr_pulses), 32'd2);
    chk("ovr.count",  32'(bus.out_ovr_count), 32'd2);
    chk("ovr.pend4",  32'(bus.out_pending[4]), 32'd0);
    bus.in_ready = 1'b1; tick("ovr_drain");
    repeat (4) tick("ovr_drain");

    // Async reset while a grant is on offer
    bus.in_ready = 1'b0;
    bus.in_gs = 1'b1; bus.in_data = 3'd5; tick("arst");
    bus.in_data = 3'd2; tick("arst");
    bus.in_gs = 1'b0;
    chk("arst.pre_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("arst.valid",   32'(bus.out_valid),   32'd0);
    chk("arst.pending", 32'(bus.out_pending), 32'd0);
    chk("arst.grant",   32'(bus.out_grant),   32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick("arst_after");
      chk("arst.no_grant", 32'(bus.out_valid), 32'd0);
    end

    // Saturation: hammer the granted line while it is stalled
    bus.in_gs = 1'b1; bus.in_data = 3'd0; tick("sat");
    bus.in_gs = 1'b0; tick("sat");
    bus.in_gs = 1'b1;
    for (int i = 0; i < OVR_SAT + 5; i++) tick("sat");
    chk("sat.count", 32'(bus.out_ovr_count), 32'(OVR_SAT));
    bus.in_gs = 1'b0; bus.in_ready = 1'b1;
    repeat (4) tick("sat_drain");

    // Random traffic from a fresh reset
    #2 rst_n = 1'b0;
    #1 m_reset();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      bus.in_gs     = 1'($urandom_range(0, 1));
      bus.in_data   = 3'($urandom_range(0, 7));
      bus.in_enable = ($urandom_range(0, 7) != 0);
      bus.in_ready  = 1'($urandom_range(0, 1));
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
